// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;

    localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder made of two chained half-adder stages
// whose carries are ORed together.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // part[0] enters stage 0 with b, part[1] enters stage 1 with cin.
    logic [2:0] part;
    logic [1:0] addend;
    logic [1:0] half_carry;

    assign part[0] = a;
    assign addend  = {cin, b};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_half_adder
            assign part[gi+1]     = part[gi] ^ addend[gi];
            assign half_carry[gi] = part[gi] & addend[gi];
        end
    endgenerate

    assign s    = part[2];
    assign cout = |half_carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand pair per handshake, added LSB-first
// through a single full-adder cell and a carry flop.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sa_state_t         state_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  sum_reg;
    logic              carry_reg;
    logic [CW-1:0]     count_reg;
    logic              out_valid_reg;
    logic              busy_reg;

    logic fa_s;
    logic fa_c;

    serial_fa_cell u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= 1'b0;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at [0].
                    sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    carry_reg <= fa_c;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == LAST_BIT) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Only unregistered output: must drop the instant reset asserts.
    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign carry     = carry_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=3 against an
// arithmetic a+b reference model.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, carry, busy;
    logic [7:0] a = '0, b = '0, sum;

    logic       in_valid_3 = 1'b0, in_ready_3, out_valid_3, out_ready_3 = 1'b1, carry_3, busy_3;
    logic [2:0] a_3 = '0, b_3 = '0, sum_3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .busy(busy)
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid_3), .in_ready(in_ready_3),
        .a(a_3), .b(b_3), .out_valid(out_valid_3), .out_ready(out_ready_3),
        .sum(sum_3), .carry(carry_3), .busy(busy_3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || sum !== 8'h00 || carry !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_w8: in_ready=%b out_valid=%b sum=%h carry=%b busy=%b, required 0 0 00 0 0",
                     in_ready, out_valid, sum, carry, busy);
        end
        n_vec++;
        if (in_ready_3 !== 1'b0 || out_valid_3 !== 1'b0 || sum_3 !== 3'h0 || carry_3 !== 1'b0 || busy_3 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_w3: in_ready=%b out_valid=%b sum=%h carry=%b busy=%b, required 0 0 0 0 0",
                     in_ready_3, out_valid_3, sum_3, carry_3, busy_3);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || in_ready_3 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b/%b, required 1/1", in_ready, in_ready_3);
        end
        $display("reset: checked");
        tick();
    endtask

    task automatic test_basic_adds();
        logic [7:0] ta [3] = '{8'h0F, 8'hFF, 8'h80};
        logic [7:0] tb [3] = '{8'h01, 8'h01, 8'h80};
        logic [8:0] expv;
        for (int i = 0; i < 3; i++) begin
            expv = {1'b0, ta[i]} + {1'b0, tb[i]};
            a = ta[i]; b = tb[i]; in_valid = 1'b1; out_ready = 1'b1;
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL basic_accept[%0d]: in_ready=%b, required 1", i, in_ready);
            end
            tick();
            in_valid = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (k < 8) begin
                    n_vec++;
                    if (out_valid !== 1'b0 || busy !== 1'b1) begin
                        n_err++;
                        $display("FAIL basic_latency[%0d] cycle %0d: out_valid=%b busy=%b, required 0 1", i, k, out_valid, busy);
                    end
                end
            end
            n_vec++;
            if (out_valid !== 1'b1 || {carry, sum} !== expv) begin
                n_err++;
                $display("FAIL basic_result[%0d]: out_valid=%b carry/sum=%b/%h, required 1 %b/%h",
                         i, out_valid, carry, sum, expv[8], expv[7:0]);
            end
            tick();
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL basic_release[%0d]: out_valid=%b in_ready=%b, required 0 1", i, out_valid, in_ready);
            end
            $display("basic: a=%h b=%h -> carry=%b sum=%h", ta[i], tb[i], expv[8], expv[7:0]);
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] expv = {1'b0, 8'h3C} + {1'b0, 8'h0A};
        a = 8'h3C; b = 8'h0A; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        n_vec++;
        if (out_valid !== 1'b1 || {carry, sum} !== expv) begin
            n_err++;
            $display("FAIL bp_result: out_valid=%b carry/sum=%b/%h, required 1 %b/%h", out_valid, carry, sum, expv[8], expv[7:0]);
        end
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || {carry, sum} !== expv || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b carry/sum=%b/%h in_ready=%b, required 1 %b/%h 0",
                         k, out_valid, carry, sum, in_ready, expv[8], expv[7:0]);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        repeat (3) tick();
        n_vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_no_queue: busy=%b out_valid=%b, required 0 0", busy, out_valid);
        end
        $display("backpressure: a=3c b=0a held 5 cycles");
    endtask

    task automatic test_reset_mid();
        logic       seen_valid = 1'b0;
        logic [8:0] expv = {1'b0, 8'h55} + {1'b0, 8'hAA};
        a = 8'h07; b = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || sum !== 8'h00 || carry !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_async: out_valid=%b sum=%h carry=%b busy=%b in_ready=%b, required 0 00 0 0 0",
                     out_valid, sum, carry, busy, in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_ready: in_ready=%b, required 1", in_ready);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        n_vec++;
        if (seen_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_discard: out_valid seen=%b, required 0", seen_valid);
        end
        a = 8'h55; b = 8'hAA; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        n_vec++;
        if (out_valid !== 1'b1 || {carry, sum} !== expv) begin
            n_err++;
            $display("FAIL midreset_after: out_valid=%b carry/sum=%b/%h, required 1 %b/%h", out_valid, carry, sum, expv[8], expv[7:0]);
        end
        tick();
        $display("reset_mid: discarded op, then a=55 b=aa -> %b/%h", expv[8], expv[7:0]);
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp1 = {1'b0, 8'h00} + {1'b0, 8'h00};
        logic [8:0] exp2 = {1'b0, 8'h01} + {1'b0, 8'hFF};
        a = 8'h00; b = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        a = 8'h01; b = 8'hFF;
        repeat (8) tick();
        n_vec++;
        if (out_valid !== 1'b1 || {carry, sum} !== exp1) begin
            n_err++;
            $display("FAIL b2b_first: out_valid=%b carry/sum=%b/%h, required 1 %b/%h", out_valid, carry, sum, exp1[8], exp1[7:0]);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap: out_valid=%b in_ready=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_accept: busy=%b in_ready=%b, required 1 0", busy, in_ready);
        end
        repeat (8) tick();
        n_vec++;
        if (out_valid !== 1'b1 || {carry, sum} !== exp2) begin
            n_err++;
            $display("FAIL b2b_second: out_valid=%b carry/sum=%b/%h, required 1 %b/%h", out_valid, carry, sum, exp2[8], exp2[7:0]);
        end
        tick();
        $display("back_to_back: 00+00 -> %b/%h, 01+ff -> %b/%h", exp1[8], exp1[7:0], exp2[8], exp2[7:0]);
    endtask

    task automatic test_random_w8();
        logic [7:0] ra, rb;
        logic [8:0] expv;
        logic       hold;
        int n_c0 = 0, n_c1 = 0, n_zero = 0, n_ones = 0;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0:       ra = 8'h00;
                1:       ra = 8'hFF;
                default: ra = 8'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 8'h00;
                1:       rb = 8'hFF;
                default: rb = 8'($urandom);
            endcase
            expv = {1'b0, ra} + {1'b0, rb};
            if (expv[8]) n_c1++; else n_c0++;
            if (ra == 8'h00 || rb == 8'h00) n_zero++;
            if (ra == 8'hFF || rb == 8'hFF) n_ones++;
            repeat ($urandom_range(0, 2)) tick();
            a = ra; b = rb; in_valid = 1'b1;
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL rand8_accept[%0d]: in_ready=%b, required 1", i, in_ready);
            end
            tick();
            in_valid = 1'b0;
            repeat (8) tick();
            n_vec++;
            if (out_valid !== 1'b1 || {carry, sum} !== expv) begin
                n_err++;
                $display("FAIL rand8_result[%0d]: a=%h b=%h out_valid=%b carry/sum=%b/%h, required 1 %b/%h",
                         i, ra, rb, out_valid, carry, sum, expv[8], expv[7:0]);
            end
            for (int s = 0; s < 16; s++) begin
                hold = (s == 15) ? 1'b1 : 1'($urandom);
                out_ready = hold;
                tick();
                if (hold) break;
                n_vec++;
                if (out_valid !== 1'b1 || {carry, sum} !== expv) begin
                    n_err++;
                    $display("FAIL rand8_stall[%0d]: out_valid=%b carry/sum=%b/%h, required 1 %b/%h",
                             i, out_valid, carry, sum, expv[8], expv[7:0]);
                end
            end
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rand8_release[%0d]: out_valid=%b, required 0", i, out_valid);
            end
        end
        n_vec++;
        if (n_c0 == 0 || n_c1 == 0 || n_zero == 0 || n_ones == 0) begin
            n_err++;
            $display("FAIL rand8_coverage: carry0=%0d carry1=%0d zero=%0d ones=%0d, required all nonzero", n_c0, n_c1, n_zero, n_ones);
        end
        $display("random_w8: 1000 ops, carry0=%0d carry1=%0d zero=%0d ones=%0d", n_c0, n_c1, n_zero, n_ones);
    endtask

    task automatic test_random_w3();
        logic [2:0] ra, rb;
        logic [3:0] expv;
        logic       hold;
        int n_c0 = 0, n_c1 = 0, n_zero = 0, n_ones = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 3'($urandom);
            rb = 3'($urandom);
            expv = {1'b0, ra} + {1'b0, rb};
            if (expv[3]) n_c1++; else n_c0++;
            if (ra == 3'h0 || rb == 3'h0) n_zero++;
            if (ra == 3'h7 || rb == 3'h7) n_ones++;
            repeat ($urandom_range(0, 2)) tick();
            a_3 = ra; b_3 = rb; in_valid_3 = 1'b1;
            n_vec++;
            if (in_ready_3 !== 1'b1) begin
                n_err++;
                $display("FAIL rand3_accept[%0d]: in_ready=%b, required 1", i, in_ready_3);
            end
            tick();
            in_valid_3 = 1'b0;
            repeat (2) tick();
            n_vec++;
            if (out_valid_3 !== 1'b0) begin
                n_err++;
                $display("FAIL rand3_early[%0d]: out_valid=%b, required 0", i, out_valid_3);
            end
            tick();
            n_vec++;
            if (out_valid_3 !== 1'b1 || {carry_3, sum_3} !== expv) begin
                n_err++;
                $display("FAIL rand3_result[%0d]: a=%h b=%h out_valid=%b carry/sum=%b/%h, required 1 %b/%h",
                         i, ra, rb, out_valid_3, carry_3, sum_3, expv[3], expv[2:0]);
            end
            for (int s = 0; s < 16; s++) begin
                hold = (s == 15) ? 1'b1 : 1'($urandom);
                out_ready_3 = hold;
                tick();
                if (hold) break;
                n_vec++;
                if (out_valid_3 !== 1'b1 || {carry_3, sum_3} !== expv) begin
                    n_err++;
                    $display("FAIL rand3_stall[%0d]: out_valid=%b carry/sum=%b/%h, required 1 %b/%h",
                             i, out_valid_3, carry_3, sum_3, expv[3], expv[2:0]);
                end
            end
            n_vec++;
            if (out_valid_3 !== 1'b0) begin
                n_err++;
                $display("FAIL rand3_release[%0d]: out_valid=%b, required 0", i, out_valid_3);
            end
        end
        n_vec++;
        if (n_c0 == 0 || n_c1 == 0 || n_zero == 0 || n_ones == 0) begin
            n_err++;
            $display("FAIL rand3_coverage: carry0=%0d carry1=%0d zero=%0d ones=%0d, required all nonzero", n_c0, n_c1, n_zero, n_ones);
        end
        $display("random_w3: 1000 ops, carry0=%0d carry1=%0d zero=%0d ones=%0d", n_c0, n_c1, n_zero, n_ones);
    endtask

    initial begin
        test_reset();
        test_basic_adds();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random_w8();
        test_random_w3();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that consumes one operand pair over a valid/ready handshake and adds it LSB-first, one bit per clock, through a single full-adder cell and a carry flop. It sits directly downstream of the combinational adder cells in the arithmetic datapath. It reuses the single-bit add function sequentially instead of instantiating WIDTH copies, trading latency for area. The result (sum plus carry-out) is presented on a valid/ready output port.

## Interface
- WIDTH, 8, operand/sum width; legal range WIDTH >= 2
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair on a/b is valid
- in_ready  output  1  block can accept an operand pair
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  sum/carry valid
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  registered result, a+b mod 2^WIDTH
- carry  output  1  registered carry-out of bit WIDTH-1
- busy  output  1  high in SHIFT or DONE

## Operation
- FSM states:
  - IDLE: in_ready=1. When in_valid=1, load shift registers A<=a and B<=b, clear the carry flop, set count=0, and go to SHIFT.
  - SHIFT: each cycle computes s=A[0]^B[0]^c and c'=majority(A[0],B[0],c).
    - Shift the sum register right, inserting s at the MSB.
    - Shift A and B right; carry flop <= c'; count++.
    - When count==WIDTH-1 (last bit), go to DONE.
  - DONE: out_valid=1; sum and carry held stable. When out_ready=1, go to IDLE.
- in_ready is asserted only in IDLE and is forced low while rst=1.
- in_valid is ignored outside IDLE; no queuing.
- sum and carry are meaningful only while out_valid=1. During SHIFT the sum register holds partial contents.
- carry output is the carry flop value captured on the final SHIFT cycle.
- Counter width is $clog2(WIDTH); the terminal compare is against WIDTH-1 at counter width.
- Reset, asynchronous and valid at any time including mid-SHIFT or in DONE:
  - state=IDLE, out_valid=0, sum=0, carry=0, count=0, A=B=0, busy=0.
  - An operation in flight is discarded and no out_valid is produced for it.

## Timing
- Acceptance edge E (in_valid and in_ready both high): state becomes SHIFT after E.
- The WIDTH SHIFT cycles occupy edges E+1 to E+WIDTH.
- out_valid rises after edge E+WIDTH, exactly WIDTH cycles after acceptance.
- The result is consumed on the first edge with out_valid and out_ready both high. IDLE (in_ready=1) follows the next cycle.
- Minimum initiation interval is WIDTH+2 cycles, with out_ready tied high.
- With out_ready low, DONE persists indefinitely. sum, carry and out_valid must not change.
- All outputs except in_ready are registered. in_ready is decoded from state and rst.

## Structure
- Package serial_adder_pkg contains:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t
  - localparam SA_DEFAULT_WIDTH = 8
- Sub-module serial_fa_cell: combinational 1-bit full adder built from two half-adder cells plus an OR on the carries. It is instantiated once.
- Top level contains the FSM, the A/B/sum shift registers, the carry flop and the counter.

## Test plan
- a=8'h0F, b=8'h01, out_ready=1 -> sum=8'h10, carry=0; out_valid rises exactly 8 cycles after acceptance and is high for 1 cycle.
- a=8'hFF, b=8'h01 -> sum=8'h00, carry=1; a=8'h80, b=8'h80 -> sum=8'h00, carry=1.
- Backpressure: a=8'h3C, b=8'h0A, out_ready low for 5 cycles -> sum=8'h46, carry=0 held stable; in_ready=0; a second in_valid during this time is ignored.
- Reset mid-operation: assert rst at SHIFT cycle 3 -> out_valid=0, sum=0, carry=0 immediately; in_ready=1 after release. Then a=8'h55, b=8'hAA -> sum=8'hFF, carry=0.
- Back-to-back: in_valid held high with a=0,b=0 then a=8'h01,b=8'hFF -> results 8'h00/0 then 8'h00/1; second acceptance occurs 1 cycle after the first result handshake.
- Random: 1000 operand pairs at WIDTH=8 and WIDTH=3 with random out_ready -> {carry,sum} equals a+b. Coverage must hit carry=0 and carry=1, and operands at 0 and at all-ones.
